// File: rtl/line_fetcher_pkg.sv
// Shared definitions for the line fetcher: geometry, FSM states and the
// line-address helper.
package line_fetcher_pkg;

   localparam int LF_FULL_WIDTH = 512;
   localparam int LF_WIDTH      = 64;
   localparam int LF_ADDR_WIDTH = 64;
   localparam int LF_CNT_WIDTH  = 32;
   localparam int LF_OFF_BITS   = $clog2(LF_FULL_WIDTH / 8);
   localparam int LF_IDX_BITS   = $clog2(LF_FULL_WIDTH / LF_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_OUT
   } lf_state_e;

   // Clears the byte offset within a memory line.
   function automatic logic [LF_ADDR_WIDTH-1:0] line_addr(input logic [LF_ADDR_WIDTH-1:0] addr);
      logic [LF_ADDR_WIDTH-1:0] mask;
      mask = '1;
      mask[LF_OFF_BITS-1:0] = '0;
      return addr & mask;
   endfunction

endpackage

// File: rtl/line_fetcher_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter
   import line_fetcher_pkg::*;
#(
   parameter int W = LF_CNT_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/line_fetcher.sv
// Fetches the 512-bit line enclosing a 64-bit element address, with a
// one-line buffer so repeated accesses to the same line skip memory.
module line_fetcher
   import line_fetcher_pkg::*;
#(
   parameter int FULL_WIDTH = LF_FULL_WIDTH,
   parameter int WIDTH      = LF_WIDTH,
   parameter int ADDR_WIDTH = LF_ADDR_WIDTH,
   parameter int IDX_BITS   = $clog2(FULL_WIDTH / WIDTH),
   parameter int OFF_BITS   = $clog2(FULL_WIDTH / 8)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   input  logic                  flush,
   output logic                  mem_rd_valid,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                  mem_rd_ready,
   input  logic                  mem_resp_valid,
   input  logic [FULL_WIDTH-1:0] mem_resp_data,
   output logic                  out_valid,
   output logic [FULL_WIDTH-1:0] out_line,
   output logic [IDX_BITS-1:0]   out_idx,
   input  logic                  out_ready,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   lf_state_e             state, state_nx;
   logic [ADDR_WIDTH-1:0] req_line;
   logic [IDX_BITS-1:0]   req_idx;
   logic [ADDR_WIDTH-1:0] line_tag;
   logic [FULL_WIDTH-1:0] line_data;
   logic                  tag_valid;
   logic                  flush_pending;
   logic                  accept, hit, miss, resp_take;

   // A flush in the same cycle as a request forces that request to miss.
   assign accept    = (state == ST_IDLE) && req_valid;
   assign hit       = accept && tag_valid && !flush && (line_tag == line_addr(req_addr));
   assign miss      = accept && !hit;
   assign resp_take = (state == ST_WAIT) && mem_resp_valid;

   always_comb begin
      state_nx     = state;
      req_ready    = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_addr  = '0;
      out_valid    = 1'b0;
      out_line     = '0;
      out_idx      = '0;
      case (state)
         ST_IDLE: begin
            req_ready = !rst;
            if (req_valid) state_nx = hit ? ST_OUT : ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_rd_valid = 1'b1;
            mem_rd_addr  = req_line;
            if (mem_rd_ready) state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_resp_valid) state_nx = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            out_line  = line_data;
            out_idx   = req_idx;
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         tag_valid     <= 1'b0;
         flush_pending <= 1'b0;
      end else begin
         state <= state_nx;
         if (flush) tag_valid <= 1'b0;
         if (flush && (state != ST_IDLE)) flush_pending <= 1'b1;
         if ((state == ST_OUT) && out_ready) flush_pending <= 1'b0;
         // A flush seen anywhere during the fetch leaves the buffer invalid.
         if (resp_take) tag_valid <= !(flush_pending || flush);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         req_line <= line_addr(req_addr);
         req_idx  <= req_addr[OFF_BITS-1 -: IDX_BITS];
      end
      if (resp_take) begin
         line_data <= mem_resp_data;
         line_tag  <= req_line;
      end
   end

   sat_counter #(.W(32)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit),
      .count (hit_count)
   );

   sat_counter #(.W(32)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss),
      .count (miss_count)
   );

endmodule

// File: tb/tb_line_fetcher.sv
// Randomized bench for line_fetcher against a transaction-level model of
// the one-line buffer, memory fetches and statistics.
module tb_line_fetcher;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic [63:0]  req_addr;
   logic         req_ready;
   logic         flush;
   logic         mem_rd_valid;
   logic [63:0]  mem_rd_addr;
   logic         mem_rd_ready;
   logic         mem_resp_valid;
   logic [511:0] mem_resp_data;
   logic         out_valid;
   logic [511:0] out_line;
   logic [2:0]   out_idx;
   logic         out_ready;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: buffered line, its tag and validity, statistics.
   bit           m_tv;
   logic [63:0]  m_tag;
   logic [511:0] m_data;
   logic [31:0]  m_hit, m_miss;

   always #5 clk = ~clk;

   line_fetcher dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .flush          (flush),
      .mem_rd_valid   (mem_rd_valid),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_ready   (mem_rd_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .out_valid      (out_valid),
      .out_line       (out_line),
      .out_idx        (out_idx),
      .out_ready      (out_ready),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [511:0] rand_line();
      logic [511:0] d;
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   // flush_at: 0 none, 1 with the request in IDLE, 2 during WAIT, 3 during OUT.
   task automatic do_req(input logic [63:0] a, input int rd_stall, input int resp_lat,
                         input int out_stall, input int flush_at);
      logic [63:0]  ln;
      logic [2:0]   ix;
      bit           hit;
      logic [511:0] d;
      ln = a - (a % 64);
      ix = 3'((a % 64) / 8);
      @(negedge clk);
      check("req_ready_idle", {511'd0, req_ready}, 512'd1);
      if (flush_at == 1) m_tv = 0;
      hit = m_tv && (m_tag == ln);
      req_valid = 1'b1;
      req_addr  = a;
      flush     = (flush_at == 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      req_addr  = {$urandom, $urandom};
      if (!hit) begin
         m_miss = sat_inc(m_miss);
         for (int i = 0; i <= rd_stall; i++) begin
            @(negedge clk);
            check("rd_valid", {511'd0, mem_rd_valid}, 512'd1);
            check("rd_addr", {448'd0, mem_rd_addr}, {448'd0, ln});
            check("out_valid_issue", {511'd0, out_valid}, 512'd0);
            if (i == rd_stall) mem_rd_ready = 1'b1;
         end
         @(posedge clk); #1;
         mem_rd_ready = 1'b0;
         if (flush_at == 2) begin
            flush = 1'b1;
            @(negedge clk);
            check("rd_once_flush", {511'd0, mem_rd_valid}, 512'd0);
            @(posedge clk); #1;
            flush = 1'b0;
         end
         for (int i = 0; i < resp_lat; i++) begin
            @(negedge clk);
            check("rd_once", {511'd0, mem_rd_valid}, 512'd0);
            check("out_valid_wait", {511'd0, out_valid}, 512'd0);
         end
         d = rand_line();
         mem_resp_valid = 1'b1;
         mem_resp_data  = d;
         @(posedge clk); #1;
         mem_resp_valid = 1'b0;
         mem_resp_data  = rand_line();
         m_data = d;
         m_tag  = ln;
         m_tv   = (flush_at != 2);
      end else begin
         m_hit = sat_inc(m_hit);
      end
      if (flush_at == 3) m_tv = 0;
      for (int i = 0; i <= out_stall; i++) begin
         @(negedge clk);
         check("out_valid", {511'd0, out_valid}, 512'd1);
         check("out_line", out_line, m_data);
         check("out_idx", {509'd0, out_idx}, {509'd0, ix});
         if (hit) check("hit_no_read", {511'd0, mem_rd_valid}, 512'd0);
         flush = (i == 0) && (flush_at == 3);
         if (i == out_stall) out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      check("out_done", {511'd0, out_valid}, 512'd0);
      check("hit_count", {480'd0, hit_count}, {480'd0, m_hit});
      check("miss_count", {480'd0, miss_count}, {480'd0, m_miss});
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; flush = 1'b0;
      mem_rd_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      out_ready = 1'b0;
      m_tv = 0; m_tag = '0; m_data = '0; m_hit = '0; m_miss = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("req_ready_in_rst", {511'd0, req_ready}, 512'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {511'd0, req_ready}, 512'd1);
      check("rst_rd_valid", {511'd0, mem_rd_valid}, 512'd0);
      check("rst_rd_addr", {448'd0, mem_rd_addr}, 512'd0);
      check("rst_out_valid", {511'd0, out_valid}, 512'd0);
      check("rst_out_line", out_line, 512'd0);
      check("rst_out_idx", {509'd0, out_idx}, 512'd0);
      check("rst_hits", {480'd0, hit_count}, 512'd0);
      check("rst_misses", {480'd0, miss_count}, 512'd0);

      // Miss then hit in the same line, then a line change.
      do_req(64'h1008, 0, 1, 0, 0);
      do_req(64'h1038, 0, 0, 0, 0);
      do_req(64'h1040, 0, 0, 0, 0);
      // Backpressure on both handshakes.
      do_req(64'h1080, 5, 2, 3, 0);
      // Flush during WAIT: delivered, but the next access to the line misses.
      do_req(64'h2010, 0, 1, 0, 2);
      do_req(64'h2018, 0, 0, 0, 0);

      // Reset while waiting for memory; the late response must be dropped.
      @(negedge clk);
      req_valid = 1'b1; req_addr = 64'h5000; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0; mem_rd_ready = 1'b1;
      @(posedge clk); #1;
      mem_rd_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_req_ready", {511'd0, req_ready}, 512'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = rand_line();
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      m_tv = 0; m_hit = '0; m_miss = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("late_resp_out_valid", {511'd0, out_valid}, 512'd0);
         check("late_resp_rd_valid", {511'd0, mem_rd_valid}, 512'd0);
         check("late_resp_req_ready", {511'd0, req_ready}, 512'd1);
      end
      check("mid_rst_hits", {480'd0, hit_count}, 512'd0);
      check("mid_rst_misses", {480'd0, miss_count}, 512'd0);

      // Randomized traffic over a few neighbouring lines.
      for (int t = 0; t < 40; t++) begin
         int fa;
         fa = int'($urandom_range(0, 7));
         if (fa > 3) fa = 0;
         do_req(64'h3000 + 64'($urandom_range(0, 3)) * 64 + 64'($urandom_range(0, 63)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), fa);
      end

      // Saturation of the miss counter.
      @(negedge clk);
      force dut.u_miss_cnt.count = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.u_miss_cnt.count;
      m_miss = 32'hFFFF_FFFE;
      do_req(64'h7000, 0, 0, 0, 1);
      do_req(64'h7008, 0, 0, 0, 1);
      do_req(64'h7010, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/line_fetcher.md
# line_fetcher

Upstream feeder for the word-slice parser. Accepts byte addresses of 64-bit elements (e.g. rank or edge entries), fetches the enclosing 512-bit memory line, and presents line plus word index to the parser with a valid/ready handshake. A one-line buffer short-circuits repeated accesses to the same line, which is common for sequential edge-list walks. Sits between the vertex/edge address generator and the parser.

## Interface
- FULL_WIDTH, 512, memory line width in bits
- WIDTH, 64, element width in bits
- ADDR_WIDTH, 64, byte address width
- IDX_BITS, 3, log2(FULL_WIDTH/WIDTH)
- OFF_BITS, 6, log2(FULL_WIDTH/8), line byte-offset bits

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  element request present
- req_addr  in  ADDR_WIDTH  element byte address
- req_ready  out  1  block can accept a request
- flush  in  1  invalidate line buffer
- mem_rd_valid  out  1  line read request
- mem_rd_addr  out  ADDR_WIDTH  line-aligned address (low OFF_BITS zero)
- mem_rd_ready  in  1  memory accepts read
- mem_resp_valid  in  1  read data present (one-cycle pulse)
- mem_resp_data  in  FULL_WIDTH  line data
- out_valid  out  1  line/idx valid for parser
- out_line  out  FULL_WIDTH  buffered line, bit 0 = MSB-first ordering as delivered by memory
- out_idx  out  IDX_BITS  word index within line
- out_ready  in  1  parser consumed output
- hit_count, miss_count  out  32 each  saturating statistics

## Operation
- Address split: line = req_addr with [OFF_BITS-1:0] cleared; idx = req_addr[OFF_BITS-1:OFF_BITS-IDX_BITS]; low 3 bits ignored (unaligned addresses truncated).
- Line buffer: registers line_tag, line_data, tag_valid.
- FSM states IDLE, ISSUE, WAIT, OUT.
  - IDLE: req_ready=1. On req_valid: latch line/idx. If tag_valid and tag matches -> OUT, hit_count+1. Else -> ISSUE, miss_count+1.
  - ISSUE: mem_rd_valid=1, mem_rd_addr=latched line; on mem_rd_ready -> WAIT.
  - WAIT: on mem_resp_valid capture data into line_data, set line_tag, tag_valid=1 (unless flush_pending) -> OUT.
  - OUT: out_valid=1 with out_line=line_data, out_idx=latched idx; on out_ready -> IDLE.
- flush: in IDLE clears tag_valid that cycle; a req_valid in the same cycle is treated as miss. In ISSUE/WAIT/OUT sets flush_pending; current request still completes with fetched data, but tag_valid ends 0; flush_pending cleared on return to IDLE.
- mem_resp_valid outside WAIT is ignored (memory read latency ≥1 cycle after handshake required).
- Counters saturate at 0xFFFF_FFFF; never wrap.

## Timing
- Reset: state IDLE, tag_valid=0, flush_pending=0, counters 0, mem_rd_valid=0, out_valid=0, out_line=0, out_idx=0, mem_rd_addr=0; req_ready=0 while rst high, 1 first cycle after.
- Reset mid-operation aborts any request; a late memory response is dropped.
- Hit: request accepted cycle N -> out_valid cycle N+1.
- Miss: accepted N -> mem_rd_valid N+1; read handshake cycle M -> WAIT from M+1; response at cycle R -> out_valid R+1.
- mem_rd_valid and out_valid held stable with their payloads until handshake.
- Throughput: one request per ≥2 cycles (IDLE and OUT each occupy a cycle).

## Structure
- Shared package: state enum, OFF_BITS/IDX_BITS derivation, line-address helper function.
- Sub-module sat_counter (32-bit saturating increment), instantiated twice.
- Parser instantiated externally on out_line/out_idx with ready=out_valid.

## Test plan
- Miss then hit: req 0x1008 -> mem_rd_addr 0x1000, response D -> out_idx 1, out_line D; then req 0x1038 -> no mem read, out_valid next cycle, out_idx 7; hit=1, miss=1.
- Line change: after 0x1000 fetch, req 0x1040 -> new read at 0x1040, miss=2.
- Backpressure: mem_rd_ready low 5 cycles, out_ready low 3 cycles -> mem_rd_addr/out_line/out_idx stable throughout, no duplicate read.
- Flush in WAIT: req 0x2010, flush during WAIT -> output delivered (idx 2); next req 0x2018 misses.
- Reset mid-WAIT, then late mem_resp_valid -> ignored, out_valid stays 0, counters 0.
- Saturation: preload via force/long run to 0xFFFF_FFFF misses -> extra miss leaves miss_count 0xFFFF_FFFF.
